// File: rtl/rgb_pkg.sv
// Shared types for the RGB colour-wheel fader: segment encoding and the
// hard colours shown in step mode, packed as {R,G,B}.
package rgb_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // red
    S1 = 3'd1,  // yellow
    S2 = 3'd2,  // green
    S3 = 3'd3,  // cyan
    S4 = 3'd4,  // blue
    S5 = 3'd5   // magenta
  } seg_e;

  localparam logic [2:0] COL_S0  = 3'b100;
  localparam logic [2:0] COL_S1  = 3'b110;
  localparam logic [2:0] COL_S2  = 3'b010;
  localparam logic [2:0] COL_S3  = 3'b011;
  localparam logic [2:0] COL_S4  = 3'b001;
  localparam logic [2:0] COL_S5  = 3'b101;
  localparam logic [2:0] COL_OFF = 3'b000;

  function automatic logic [2:0] step_col(input seg_e s);
    case (s)
      S0:      step_col = COL_S0;
      S1:      step_col = COL_S1;
      S2:      step_col = COL_S2;
      S3:      step_col = COL_S3;
      S4:      step_col = COL_S4;
      S5:      step_col = COL_S5;
      default: step_col = COL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM comparator with a registered active-low LED drive.
// Full-scale duty is forced on so the channel never blinks at the top of the count.
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] duty,
  output logic                lit_n
);

  localparam logic [PWM_BITS-1:0] M = '1;

  logic w_lit;
  assign w_lit = (duty == M) || (duty > cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lit_n <= 1'b1;
    else        lit_n <= ~w_lit;
  end

endmodule

// File: rtl/rgb_fader.sv
// RGB colour-wheel driver: six segments, each either a hard colour (step mode)
// or a linear cross-fade to the next colour (fade mode), shown through 3 PWMs.
module rgb_fader
  import rgb_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int PWM_BITS  = 8,
  parameter int STEP_CLKS = (CLK_HZ + 3 * (2 ** PWM_BITS)) / (6 * (2 ** PWM_BITS))
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       pause,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] seg
);

  localparam int PRE_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CLKS - 1);
  localparam logic [PWM_BITS-1:0] M        = '1;

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_lvl;
  logic [PWM_BITS-1:0] r_cnt;
  seg_e                r_state;
  seg_e                w_next;
  logic                w_tick;
  logic                w_lvl_wrap;
  logic [2:0]          w_col;
  logic [2:0][PWM_BITS-1:0] w_duty;  // [2]=R, [1]=G, [0]=B
  logic [2:0]          w_lit_n;

  assign w_tick     = !pause && (r_pre == PRE_LAST);
  assign w_lvl_wrap = w_tick && (r_lvl == M);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_lvl <= '0;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (!pause) r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_lvl <= r_lvl + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S0;
    else        r_state <= w_next;
  end

  // Illegal codes fall through to S0 regardless of tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S0:      if (w_lvl_wrap) w_next = S1;
      S1:      if (w_lvl_wrap) w_next = S2;
      S2:      if (w_lvl_wrap) w_next = S3;
      S3:      if (w_lvl_wrap) w_next = S4;
      S4:      if (w_lvl_wrap) w_next = S5;
      S5:      if (w_lvl_wrap) w_next = S0;
      default: w_next = S0;
    endcase
  end

  always_comb begin
    w_col  = step_col(r_state);
    w_duty = '0;
    if (!mode) begin
      for (int i = 0; i < 3; i++) w_duty[i] = w_col[i] ? M : '0;
    end else begin
      case (r_state)
        S0:      w_duty = {M,         r_lvl,     {PWM_BITS{1'b0}}};
        S1:      w_duty = {M - r_lvl, M,         {PWM_BITS{1'b0}}};
        S2:      w_duty = {{PWM_BITS{1'b0}}, M,  r_lvl};
        S3:      w_duty = {{PWM_BITS{1'b0}}, M - r_lvl, M};
        S4:      w_duty = {r_lvl,     {PWM_BITS{1'b0}}, M};
        S5:      w_duty = {M,         {PWM_BITS{1'b0}}, M - r_lvl};
        default: w_duty = '0;
      endcase
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (r_cnt),
      .duty  (w_duty[g]),
      .lit_n (w_lit_n[g])
    );
  end

  assign RGB_R = w_lit_n[2];
  assign RGB_G = w_lit_n[1];
  assign RGB_B = w_lit_n[0];
  assign seg   = r_state;

endmodule

// File: tb/tb_rgb_fader.sv
// Directed bench for rgb_fader at PWM_BITS=3, STEP_CLKS=2 (16 cycles per segment).
module tb_rgb_fader;

  localparam int PB = 3;
  localparam int SC = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode  = 1'b0;
  logic       pause = 1'b0;
  logic       RGB_R, RGB_G, RGB_B;
  logic [2:0] seg;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rgb_fader #(.PWM_BITS(PB), .STEP_CLKS(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .pause (pause),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B),
    .seg   (seg)
  );

  typedef struct {
    int         cycles;
    logic [2:0] seg;
    logic [2:0] rgb;   // {R,G,B}, active-low
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance n rising edges, landing on the following falling edge.
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int g_lo, r_lo, b_hi, b_lo;

    // Step-mode walk from reset release; edge counts are cumulative.
    tv[0] = '{2,  3'd0, 3'b011};
    tv[1] = '{14, 3'd1, 3'b011};
    tv[2] = '{1,  3'd1, 3'b001};
    tv[3] = '{16, 3'd2, 3'b101};
    tv[4] = '{16, 3'd3, 3'b100};
    tv[5] = '{16, 3'd4, 3'b110};
    tv[6] = '{16, 3'd5, 3'b010};
    tv[7] = '{16, 3'd0, 3'b011};

    run(3);
    chk("reset_rgb", {5'd0, RGB_R, RGB_G, RGB_B}, 8'd7);
    chk("reset_seg", {5'd0, seg}, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run(tv[i].cycles);
      chk($sformatf("step%0d_seg", i), {5'd0, seg}, {5'd0, tv[i].seg});
      chk($sformatf("step%0d_rgb", i), {5'd0, RGB_R, RGB_G, RGB_B}, {5'd0, tv[i].rgb});
    end

    // Edge 103: seg0, lvl3, prescaler one short of a tick. Freeze and fade.
    run(6);
    pause = 1'b1;
    mode  = 1'b1;
    g_lo = 0; r_lo = 0; b_hi = 0;
    for (int i = 0; i < 8; i++) begin
      run(1);
      if (!RGB_G) g_lo++;
      if (!RGB_R) r_lo++;
      if (RGB_B)  b_hi++;
    end
    chk("fade_g_low", 8'(g_lo), 8'd3);
    chk("fade_r_low", 8'(r_lo), 8'd8);
    chk("fade_b_high", 8'(b_hi), 8'd8);

    run(24);
    g_lo = 0;
    for (int i = 0; i < 8; i++) begin
      run(1);
      if (!RGB_G) g_lo++;
    end
    chk("pause_g_low", 8'(g_lo), 8'd3);
    chk("pause_seg", {5'd0, seg}, 8'd0);

    // Release at edge 143: held prescaler ticks on 144, lvl wraps on 152.
    pause = 1'b0;
    run(8);
    chk("resume_seg151", {5'd0, seg}, 8'd0);
    run(1);
    chk("resume_seg152", {5'd0, seg}, 8'd1);

    // Edge 178: seg2, lvl5 in step mode, then switch to fade.
    mode = 1'b0;
    run(26);
    chk("pre_toggle_rgb", {5'd0, RGB_R, RGB_G, RGB_B}, 8'b101);
    chk("pre_toggle_seg", {5'd0, seg}, 8'd2);
    pause = 1'b1;
    mode  = 1'b1;
    run(1);
    chk("toggle_rgb", {5'd0, RGB_R, RGB_G, RGB_B}, 8'b100);
    b_lo = RGB_B ? 0 : 1;
    for (int i = 0; i < 7; i++) begin
      run(1);
      if (!RGB_B) b_lo++;
    end
    chk("toggle_b_low", 8'(b_lo), 8'd5);
    chk("toggle_seg", {5'd0, seg}, 8'd2);

    // Resume; seg4 begins at edge 208.
    pause = 1'b0;
    run(26);
    chk("seg4_reached", {5'd0, seg}, 8'd4);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", {5'd0, RGB_R, RGB_G, RGB_B}, 8'd7);
    chk("async_rst_seg", {5'd0, seg}, 8'd0);
    #20;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
